fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage. Holds the PC and issues one-at-a-time reads to instruction memory.
//  Presents the returned word as instr/pc/pc_four to the decode/control stage.
//  Advances the PC by +4, or to the branch/jump target when the control stage asserts br_sel.
//  A flush input (trap/exception path) restarts fetch at flush_pc and discards any in-flight read.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR     32'h0000_0013  value held on instr while no valid word (addi x0,x0,0)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  br_sel       in   1   sampled only on the instr handshake: 1 = next PC is br_target
//  br_target    in   32  branch/jump target (ALU result)
//  flush        in   1   restart fetch at flush_pc; priority over everything except rst
//  flush_pc     in   32  restart address
//  imem_req     out  1   one-cycle read request pulse
//  imem_addr    out  32  read address; valid while imem_req=1; bits[1:0] always 2'b00
//  imem_rvalid  in   1   read data valid; at most one response per request, >=1 cycle after req
//  imem_rdata   in   32  read data
//  instr_valid  out  1   instr/pc/pc_four hold a fetched instruction
//  instr_ready  in   1   consumer accepts instr this cycle (handshake = valid & ready)
//  instr        out  32  fetched instruction (NOP_INSTR when instr_valid=0)
//  pc           out  32  address of instr
//  pc_four      out  32  pc + 4 (mod 2^32), feeds the wb_sel=2 link path
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - state=S_REQ, pc=RESET_VECTOR, drop=0, instr=NOP_INSTR, instr_valid=0.
//   - imem_req=0 in every cycle in which rst=1.
//  FSM:
//   - S_REQ: imem_req=1, imem_addr=pc. Next state is S_WAIT unconditionally.
//   - S_WAIT: on imem_rvalid with drop=0, capture instr<=imem_rdata and go to S_VALID.
//     On imem_rvalid with drop=1, clear drop and go to S_REQ.
//   - S_VALID: instr_valid=1; instr and pc are stable until handshake. On instr_ready:
//     pc <= br_sel ? {br_target[31:2],2'b00} : pc+4; instr<=NOP_INSTR; go to S_REQ.
//  Latency: req at cycle N, rvalid at N+k (k>=1), instr_valid from N+k+1.
//   - Best case throughput is 1 instruction per 3 cycles; only 1 read is ever outstanding.
//  Flush (rst=0, flush=1), pc <= {flush_pc[31:2],2'b00} in every case:
//   - S_REQ: the request this cycle is still issued; set drop=1 and go to S_WAIT.
//   - S_WAIT, no rvalid: drop=1, stay in S_WAIT.
//   - S_WAIT with rvalid: discard the data, drop=0, go to S_REQ.
//   - S_VALID: discard instr, ignore instr_ready/br_sel, go to S_REQ (instr_valid falls next cycle).
//  Boundary rules:
//   - imem_rvalid outside S_WAIT is ignored.
//   - br_sel/br_target are ignored without a handshake.
//   - pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; pc_four wraps the same way.
//   - Target bits[1:0] are forced to 0 (no misalign trap in this stage).
//   - rst mid-read: state returns to S_REQ and drop=0.
//     A stale rvalid arriving after reset lands in S_REQ and is ignored.
// TESTING
//  T1 reset: rst 2 cycles, RESET_VECTOR=0 -> imem_req=0 during rst; next cycle imem_req=1,
//     imem_addr=0; instr_valid=0, instr=32'h13.
//  T2 sequential: rvalid 1 cycle after each req, ready=1, br_sel=0 ->
//     addresses 0,4,8; instr_valid every 3rd cycle; pc_four=4,8,12.
//  T3 branch: handshake at pc=8 with br_sel=1, br_target=32'h0000_0103 ->
//     next imem_addr=32'h100; without handshake br_sel has no effect.
//  T4 backpressure: instr_ready=0 for 5 cycles -> instr/pc stable, no imem_req;
//     on ready=1 exactly one advance.
//  T5 flush in flight: flush, flush_pc=32'h200 one cycle after req; rvalid 3 cycles later
//     with 32'hDEADBEEF -> data never appears on instr; next imem_addr=32'h200.
//  T6 flush vs handshake same cycle in S_VALID, br_sel=1 -> flush_pc wins.
//     Wrap: pc=32'hFFFF_FFFC handshake -> next imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and issues single outstanding reads to instruction memory.
// Presents the returned word with its pc/pc_four to decode, and redirects on branch or flush.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  localparam int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_four
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_RESET   = RESET_VECTOR & ALIGN_MASK;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   drop;
  logic   handshake_c;

  assign handshake_c = (state == S_VALID) && instr_ready;
  assign imem_addr   = pc;
  assign pc_four     = pc + XLEN'(4);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a flush or pending drop turns a returning read into a refetch
  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_next = (drop || flush) ? S_REQ : S_VALID;
      S_VALID: if (flush || instr_ready) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Output decode; the request is suppressed while reset is held
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    if ((state == S_REQ) && !rst) imem_req = 1'b1;
    if (state == S_VALID) instr_valid = 1'b1;
  end

  // PC, drop flag and instruction holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= PC_RESET;
      drop  <= 1'b0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      pc    <= flush_pc & ALIGN_MASK;
      // Any read still in flight after this edge belongs to the old path
      drop  <= (state == S_REQ) || ((state == S_WAIT) && !imem_rvalid);
      instr <= NOP_INSTR;
    end else begin
      if ((state == S_WAIT) && imem_rvalid) begin
        if (drop) begin
          drop <= 1'b0;
        end else begin
          instr <= imem_rdata;
        end
      end
      if (handshake_c) begin
        pc    <= br_sel ? (br_target & ALIGN_MASK) : (pc + XLEN'(4));
        instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic, checked against
// an architectural PC model and a single-outstanding instruction memory responder.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_sel;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_four;

  int checks = 0;
  int errors = 0;

  // Memory responder state
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_data_q;
  int unsigned lat_min;
  int unsigned lat_max;
  bit          force_next;
  logic [31:0] force_val;

  // Architectural model: address of the instruction currently being fetched or presented
  logic [31:0] model_pc;
  int          hs_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR   (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .br_sel     (br_sel),
    .br_target  (br_target),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .pc         (pc),
    .pc_four    (pc_four)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the memory response for this cycle, then let combinational outputs settle
  task automatic settle();
    if (mem_pending && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data_q;
      mem_pending = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_pending) mem_cnt--;
    end
    #1;
  endtask

  // Observe what the coming edge will see, update the model, then advance one clock
  task automatic finish_cyc();
    if (rst) begin
      chk("req_in_rst", 32'(imem_req), 32'd0);
      model_pc = 32'h0000_0000;
    end else begin
      if (!instr_valid) chk("nop_idle", instr, NOP);
      if (imem_req) begin
        chk("req_addr", imem_addr, model_pc);
        chk("one_outstanding", 32'(mem_pending), 32'd0);
        mem_pending = 1'b1;
        mem_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
        mem_data_q  = force_next ? force_val : mem_word(imem_addr);
        force_next  = 1'b0;
      end
      if (flush) begin
        model_pc = flush_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
        chk("hs_pc", pc, model_pc);
        chk("hs_pc_four", pc_four, model_pc + 32'd4);
        chk("hs_instr", instr, mem_word(model_pc));
        hs_count++;
        model_pc = br_sel ? (br_target & ~32'h3) : (model_pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    finish_cyc();
  endtask

  initial begin
    int          hs0;
    bit          found;
    rst = 1'b1; br_sel = 1'b0; br_target = '0; flush = 1'b0; flush_pc = '0;
    instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_pending = 1'b0; mem_cnt = 0; mem_data_q = '0; lat_min = 1; lat_max = 1;
    force_next = 1'b0; force_val = '0; model_pc = '0; hs_count = 0;

    // Reset held for two cycles: no request may be issued
    repeat (2) begin
      settle();
      chk("rst_req", 32'(imem_req), 32'd0);
      finish_cyc();
    end
    rst = 1'b0;
    instr_ready = 1'b1;

    // Sequential fetch at 0,4,8; branch taken on the handshake at pc=8
    for (int i = 0; i < 3; i++) begin
      br_sel = 1'b1; br_target = 32'h0000_0F00;
      settle();
      chk("seq_req", 32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * i));
      chk("seq_valid0", 32'(instr_valid), 32'd0);
      chk("seq_nop", instr, NOP);
      finish_cyc();
      settle();
      chk("wait_req", 32'(imem_req), 32'd0);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      finish_cyc();
      br_sel = (i == 2);
      br_target = (i == 2) ? 32'h0000_0103 : 32'h0000_0F00;
      settle();
      chk("seq_valid1", 32'(instr_valid), 32'd1);
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_pc_four", pc_four, 32'(4 * i + 4));
      chk("seq_instr", instr, mem_word(32'(4 * i)));
      finish_cyc();
    end

    // Branch target aligned; then backpressure with br_sel asserted but no handshake
    br_sel = 1'b0;
    settle();
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'h0000_0100);
    instr_ready = 1'b0; br_sel = 1'b1; br_target = 32'h0000_0400;
    finish_cyc();
    cyc();
    repeat (5) begin
      settle();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_pc", pc, 32'h0000_0100);
      chk("bp_instr", instr, mem_word(32'h0000_0100));
      chk("bp_no_req", 32'(imem_req), 32'd0);
      finish_cyc();
    end
    instr_ready = 1'b1; br_sel = 1'b0;
    cyc();
    settle();
    chk("bp_adv_req", 32'(imem_req), 32'd1);
    chk("bp_adv_addr", imem_addr, 32'h0000_0104);
    lat_min = 4; lat_max = 4; force_next = 1'b1; force_val = 32'hDEAD_BEEF;
    finish_cyc();

    // Flush one cycle after the request; the late DEADBEEF response must be dropped
    flush = 1'b1; flush_pc = 32'h0000_0200;
    settle();
    chk("fl_valid", 32'(instr_valid), 32'd0);
    finish_cyc();
    flush = 1'b0;
    repeat (3) begin
      settle();
      chk("fl_no_req", 32'(imem_req), 32'd0);
      chk("fl_no_valid", 32'(instr_valid), 32'd0);
      finish_cyc();
    end
    lat_min = 1; lat_max = 1;
    settle();
    chk("fl_req", 32'(imem_req), 32'd1);
    chk("fl_addr", imem_addr, 32'h0000_0200);
    finish_cyc();
    cyc();
    settle();
    chk("fl_data_valid", 32'(instr_valid), 32'd1);
    chk("fl_data_pc", pc, 32'h0000_0200);
    chk("fl_data_instr", instr, mem_word(32'h0000_0200));

    // Flush beats a same-cycle branch handshake; flush target lands on the wrap point
    instr_ready = 1'b1; br_sel = 1'b1; br_target = 32'h0000_0300;
    flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
    finish_cyc();
    flush = 1'b0; br_sel = 1'b0;
    settle();
    chk("fvh_req", 32'(imem_req), 32'd1);
    chk("fvh_addr", imem_addr, 32'hFFFF_FFFC);
    chk("fvh_valid", 32'(instr_valid), 32'd0);
    finish_cyc();
    cyc();
    settle();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_four", pc_four, 32'h0000_0000);
    finish_cyc();
    settle();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    finish_cyc();

    // Randomized traffic against the model
    lat_min = 1; lat_max = 4;
    hs0 = hs_count;
    repeat (3000) begin
      instr_ready = ($urandom_range(9, 0) < 7);
      br_sel      = 1'($urandom_range(1, 0));
      br_target   = $urandom;
      flush       = ($urandom_range(19, 0) == 0);
      flush_pc    = $urandom;
      cyc();
    end
    chk("rand_progress", 32'(hs_count > hs0 + 100), 32'd1);

    // Reset mid-read: the stale response arrives in the first post-reset cycle
    flush = 1'b0; br_sel = 1'b0; instr_ready = 1'b1;
    lat_min = 2; lat_max = 2; force_next = 1'b1; force_val = 32'hBAD0_0BAD;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      found = (imem_req === 1'b1);
      finish_cyc();
    end
    chk("rr_req_seen", 32'(found), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    chk("rr_req", 32'(imem_req), 32'd1);
    chk("rr_addr", imem_addr, 32'h0000_0000);
    finish_cyc();
    hs0 = hs_count;
    for (int i = 0; i < 10 && hs_count == hs0; i++) cyc();
    chk("rr_fetch", 32'(hs_count - hs0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
